// File: rtl/atmega_uart_seq.sv
`default_nettype none
// ============================================================================
// Module      : atmega_uart_seq
// Description : Autonomous bus-master sequencer for the atmega_uart register
//               port. Programs baud divisor and frame format, enables RX/TX,
//               then polls UCSRA and moves bytes between internal TX/RX FIFOs
//               and UDR. A CPU access on the I/O bus always wins the UART port;
//               the sequencer then holds and retries on the next cycle.
// Ports       : clk, rst                 clock, synchronous active-high reset
//               cfg_start/cfg_stop       run config + polling / disable, idle
//               cfg_ubrr, cfg_ucsrc      baud divisor, frame format
//               running                  high in POLL/RD/WR
//               tx_data/valid/ready      TX FIFO push side
//               rx_data/fe/valid/ready   RX FIFO pop side (first-word-fall-through)
//               cpu_*                    CPU I/O bus side
//               u_*                      UART register port side
// Revision    : 1.0 - initial release
// ============================================================================
module atmega_uart_seq #(
    parameter int                           BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UDR_ADDR          = 'hc1,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRA_ADDR        = 'hc8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRB_ADDR        = 'hc9,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UCSRC_ADDR        = 'hca,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRL_ADDR        = 'hcc,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] UBRRH_ADDR        = 'hcd,
    parameter int                           TX_AW             = 4,
    parameter int                           RX_AW             = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_start,
    input  logic                         cfg_stop,
    input  logic [11:0]                  cfg_ubrr,
    input  logic [7:0]                   cfg_ucsrc,
    output logic                         running,
    input  logic [7:0]                   tx_data,
    input  logic                         tx_valid,
    output logic                         tx_ready,
    output logic [7:0]                   rx_data,
    output logic                         rx_fe,
    output logic                         rx_valid,
    input  logic                         rx_ready,
    input  logic [BUS_ADDR_DATA_LEN-1:0] cpu_addr,
    input  logic                         cpu_wr,
    input  logic                         cpu_rd,
    input  logic [7:0]                   cpu_bus_in,
    output logic [7:0]                   cpu_bus_out,
    output logic [BUS_ADDR_DATA_LEN-1:0] u_addr,
    output logic                         u_wr,
    output logic                         u_rd,
    output logic [7:0]                   u_bus_in,
    input  logic [7:0]                   u_bus_out
);

    localparam logic [3:0] c_IDLE  = 4'd0;
    localparam logic [3:0] c_CFG_H = 4'd1;
    localparam logic [3:0] c_CFG_L = 4'd2;
    localparam logic [3:0] c_CFG_C = 4'd3;
    localparam logic [3:0] c_CFG_B = 4'd4;
    localparam logic [3:0] c_POLL  = 4'd5;
    localparam logic [3:0] c_RD    = 4'd6;
    localparam logic [3:0] c_WR    = 4'd7;
    localparam logic [3:0] c_STOP  = 4'd8;

    localparam logic [TX_AW:0] c_TX_ONE = {{TX_AW{1'b0}}, 1'b1};
    localparam logic [RX_AW:0] c_RX_ONE = {{RX_AW{1'b0}}, 1'b1};
    localparam logic [BUS_ADDR_DATA_LEN-1:0] c_ADDR_ZERO = '0;

    logic [3:0] r_state;
    logic [3:0] w_state_nxt;
    logic       r_fe_lat;

    logic                         w_grant;
    logic                         w_stop_req;
    logic                         w_seq_en;
    logic                         w_seq_wr;
    logic                         w_seq_rd;
    logic [BUS_ADDR_DATA_LEN-1:0] w_seq_addr;
    logic [7:0]                   w_seq_data;

    // TX FIFO
    logic [7:0]   r_tx_mem [2**TX_AW];
    logic [TX_AW:0] r_tx_wp;
    logic [TX_AW:0] r_tx_rp;
    logic         w_tx_full;
    logic         w_tx_empty;
    logic         w_tx_push;
    logic         w_tx_pop;
    logic [7:0]   w_tx_head;

    // RX FIFO, entries are {fe, data}
    logic [8:0]   r_rx_mem [2**RX_AW];
    logic [RX_AW:0] r_rx_wp;
    logic [RX_AW:0] r_rx_rp;
    logic         w_rx_full;
    logic         w_rx_empty;
    logic         w_rx_push;
    logic         w_rx_pop;
    logic [8:0]   w_rx_head;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    assign w_grant = ~(cpu_wr | cpu_rd);

    // A stop request abandons the pending access, except an RD/WR that is
    // already on the bus this cycle, which is allowed to complete.
    assign w_stop_req = cfg_stop && (r_state != c_IDLE) && (r_state != c_STOP);
    assign w_seq_en   = ~(w_stop_req && (r_state != c_RD) && (r_state != c_WR));

    always_comb begin
        w_seq_wr   = 1'b0;
        w_seq_rd   = 1'b0;
        w_seq_addr = c_ADDR_ZERO;
        w_seq_data = 8'h00;
        case (r_state)
            c_CFG_H: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UBRRH_ADDR;
                w_seq_data = {4'h0, cfg_ubrr[11:8]};
            end
            c_CFG_L: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UBRRL_ADDR;
                w_seq_data = cfg_ubrr[7:0];
            end
            c_CFG_C: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UCSRC_ADDR;
                w_seq_data = cfg_ucsrc;
            end
            c_CFG_B: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UCSRB_ADDR;
                w_seq_data = 8'h18;          // RXEN | TXEN, interrupts off
            end
            c_POLL: begin
                w_seq_rd   = 1'b1;
                w_seq_addr = UCSRA_ADDR;
            end
            c_RD: begin
                w_seq_rd   = 1'b1;
                w_seq_addr = UDR_ADDR;
            end
            c_WR: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UDR_ADDR;
                w_seq_data = w_tx_head;
            end
            c_STOP: begin
                w_seq_wr   = 1'b1;
                w_seq_addr = UCSRB_ADDR;
                w_seq_data = 8'h00;
            end
            default: begin
                w_seq_wr   = 1'b0;
                w_seq_rd   = 1'b0;
            end
        endcase
    end

    always_comb begin
        if (!w_grant) begin
            u_addr      = cpu_addr;
            u_wr        = cpu_wr;
            u_rd        = cpu_rd;
            u_bus_in    = cpu_bus_in;
            cpu_bus_out = u_bus_out;
        end else begin
            u_addr      = w_seq_en ? w_seq_addr : c_ADDR_ZERO;
            u_wr        = w_seq_en & w_seq_wr;
            u_rd        = w_seq_en & w_seq_rd;
            u_bus_in    = w_seq_en ? w_seq_data : 8'h00;
            cpu_bus_out = 8'h00;
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == c_IDLE) begin
            if (cfg_start && !cfg_stop) begin
                w_state_nxt = c_CFG_H;
            end
        end else if (w_stop_req) begin
            w_state_nxt = c_STOP;
        end else if (w_grant) begin
            case (r_state)
                c_CFG_H: w_state_nxt = c_CFG_L;
                c_CFG_L: w_state_nxt = c_CFG_C;
                c_CFG_C: w_state_nxt = c_CFG_B;
                c_CFG_B: w_state_nxt = c_POLL;
                c_POLL: begin
                    // u_bus_out carries UCSRA here: bit7 RXC, bit5 UDRE
                    if (u_bus_out[7] && !w_rx_full) begin
                        w_state_nxt = c_RD;
                    end else if (u_bus_out[5] && !w_tx_empty) begin
                        w_state_nxt = c_WR;
                    end
                end
                c_RD:    w_state_nxt = c_POLL;
                c_WR:    w_state_nxt = c_POLL;
                c_STOP:  w_state_nxt = c_IDLE;
                default: w_state_nxt = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_fe_lat <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            // FE must be taken from the same UCSRA read that saw RXC, since
            // reading UDR afterwards updates the flag.
            if (w_grant && !w_stop_req && (r_state == c_POLL)) begin
                r_fe_lat <= u_bus_out[4];
            end
        end
    end

    assign running = (r_state == c_POLL) || (r_state == c_RD) || (r_state == c_WR);

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[TX_AW] != r_tx_rp[TX_AW]) &&
                        (r_tx_wp[TX_AW-1:0] == r_tx_rp[TX_AW-1:0]);
    assign tx_ready   = ~w_tx_full;
    assign w_tx_push  = tx_valid & ~w_tx_full;
    assign w_tx_pop   = w_grant && (r_state == c_WR);
    assign w_tx_head  = r_tx_mem[r_tx_rp[TX_AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + c_TX_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + c_TX_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[TX_AW-1:0]] <= tx_data;
    end

    // ------------------------------------------------------------------
    // RX FIFO
    // ------------------------------------------------------------------
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[RX_AW] != r_rx_rp[RX_AW]) &&
                        (r_rx_wp[RX_AW-1:0] == r_rx_rp[RX_AW-1:0]);
    assign rx_valid   = ~w_rx_empty;
    assign w_rx_push  = w_grant && (r_state == c_RD);
    assign w_rx_pop   = rx_ready & ~w_rx_empty;
    assign w_rx_head  = r_rx_mem[r_rx_rp[RX_AW-1:0]];

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign rx_data = w_rx_empty ? 8'h00 : w_rx_head[7:0];
    assign rx_fe   = w_rx_empty ? 1'b0  : w_rx_head[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_rx_push) r_rx_wp <= r_rx_wp + c_RX_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + c_RX_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp[RX_AW-1:0]] <= {r_fe_lat, u_bus_out};
    end

endmodule
`default_nettype wire
